// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with device ACK check.
// Define PS2_TX_TIMEOUT_EN to add the per-frame watchdog (else timeout is tied to 0).
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);
  localparam int unsigned INH_W  = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned EDGE_W = 4;
  localparam int unsigned SH_W   = 9;

  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("ps2_host_tx: INHIBIT_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_SEND, S_ACK, S_RECOVER} state_e;

  state_e            state_q, state_d;
  logic [INH_W-1:0]  inh_cnt_q, inh_cnt_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [2:0]        sync_q;
  logic [1:0]        dsync_q;
  logic              clk_oe_q, clk_oe_d;
  logic              data_oe_q, data_oe_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ack_err_q, ack_err_d;
  logic              fall, clk_s, data_s, accept;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            wd_expired;
  assign wd_expired = (wd_q >= TO_W'(TIMEOUT_CYCLES - 1));
`endif

  assign fall   = sync_q[2] & ~sync_q[1];
  assign clk_s  = sync_q[1];
  assign data_s = dsync_q[1];
  assign accept = (state_q == S_IDLE) & tx_valid & ready_q;

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    edge_d    = edge_q;
    sh_d      = sh_q;
    clk_oe_d  = 1'b0;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
`ifdef PS2_TX_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        if (accept) begin
          state_d   = S_INHIBIT;
          inh_cnt_d = '0;
          edge_d    = '0;
          sh_d      = {~^tx_data, tx_data};
          clk_oe_d  = 1'b1;
          data_oe_d = (INHIBIT_CYCLES <= 1);
          ack_err_d = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
          wd_d      = TO_W'(1);
          timeout_d = 1'b0;
`endif
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          state_d   = S_SEND;
          data_oe_d = 1'b1;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
          clk_oe_d  = 1'b1;
          data_oe_d = (inh_cnt_d == INH_W'(INHIBIT_CYCLES - 1));
        end
      end
      S_SEND: begin
        if (fall) begin
          edge_d = edge_q + EDGE_W'(1);
          if (edge_q == EDGE_W'(9)) begin
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end else begin
            data_oe_d = ~sh_q[0];
            sh_d      = {1'b0, sh_q[SH_W-1:1]};
          end
        end
      end
      S_ACK: begin
        data_oe_d = 1'b0;
        if (fall) begin
          edge_d    = edge_q + EDGE_W'(1);
          ack_err_d = data_s;
          state_d   = S_RECOVER;
        end
      end
      S_RECOVER: begin
        data_oe_d = 1'b0;
        if (clk_s & data_s) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        data_oe_d = 1'b0;
      end
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog covers the frame from accept until RECOVER is entered
    if (state_q != S_IDLE && state_q != S_RECOVER) begin
      wd_d = wd_q + TO_W'(1);
      if (wd_expired) begin
        state_d   = S_IDLE;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        done_d    = 1'b1;
        ack_err_d = 1'b1;
        timeout_d = 1'b1;
      end
    end
`endif
    ready_d = (state_d == S_IDLE) & ~done_d;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      inh_cnt_q <= '0;
      edge_q    <= '0;
      sh_q      <= '0;
      sync_q    <= 3'b111;
      dsync_q   <= 2'b11;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      edge_q    <= edge_d;
      sh_q      <= sh_d;
      sync_q    <= {sync_q[1:0], ps2_clk};
      dsync_q   <= {dsync_q[0], ps2_data};
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
`ifdef PS2_TX_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

- Host-to-device PS/2 transmitter: sends one command byte (LED set 0xED, reset 0xFF, ...) from the host to the keyboard over the open-drain PS/2 clock/data lines, and checks the device acknowledge.
- Companion to the keyboard scan-code receiver, sharing the same pins.
- `busy` tells the system to gate the receiver while a command frame is on the wire.

## Interface
Parameters:
- `INHIBIT_CYCLES`, 5000 — `clk` cycles the clock line is held low before the request (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 1000000 — watchdog limit per frame (20 ms at 50 MHz); used only with `PS2_TX_TIMEOUT_EN`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1 — system clock, sole clock.
- `clr` in 1 — synchronous, active-high reset.
- `ps2_clk` in 1 — PS/2 clock pin level.
- `ps2_data` in 1 — PS/2 data pin level.
- `ps2_clk_oe` out 1 — 1 = pull clock line low, 0 = release.
- `ps2_data_oe` out 1 — 1 = pull data line low, 0 = release.
- `tx_data` in 8 — command byte, captured on accept.
- `tx_valid` in 1 — command request.
- `tx_ready` out 1 — block idle and able to accept.
- `busy` out 1 — frame in progress (not IDLE).
- `done` out 1 — one-cycle pulse at frame end (success or failure).
- `ack_err` out 1 — frame ended without device ACK.
- `timeout` out 1 — frame aborted by watchdog.

## Operation
- Input sync: `ps2_clk` passes through a 3-bit shift register `sync`. Falling edge `fall = sync[2] & ~sync[1]`. `ps2_data` passes through 2 flops.
- Accept: in IDLE, `tx_valid & tx_ready` latches `tx_data` into the shift register. It also computes `par = ~^tx_data` (odd parity) and clears `ack_err` and `timeout`.
- States:
  - IDLE: both oe = 0, `tx_ready` = 1. Goes to INHIBIT on accept.
  - INHIBIT: `ps2_clk_oe` = 1 and a counter runs 0..INHIBIT_CYCLES-1. `ps2_data_oe` = 1 on the final count (start bit). Goes to SEND.
  - SEND: `ps2_clk_oe` = 0. On each `fall`, edge counter n increments and data is driven as `ps2_data_oe = ~bit`:
    - n=1..8: data bits, LSB first.
    - n=9: parity.
    - n=10: release data (stop bit).
    - Goes to ACK after n=10.
  - ACK: on the next `fall`, sample synced data. 0 means ACK, 1 sets `ack_err`. Goes to RECOVER.
  - RECOVER: wait until synced clock and data are both 1, then pulse `done` and return to IDLE.
- `fall` events in IDLE and INHIBIT are ignored; the counter is not affected.
- `tx_valid` while busy is ignored; the byte is not queued.
- Edge counter is 4 bits and counts 0..11 only; no wrap.

## Timing
- Reset values: `ps2_clk_oe` = 0, `ps2_data_oe` = 0, `tx_ready` = 1, `busy` = 0, `done` = 0, `ack_err` = 0, `timeout` = 0. State is IDLE and counters are 0.
- `clr` mid-frame: both lines are released on the cycle after `clr` is sampled high. `done` is not pulsed.
- Accept in cycle T: `ps2_clk_oe` = 1 and `busy` = 1 from T+1.
  - `ps2_data_oe` = 1 from T+INHIBIT_CYCLES.
  - Clock is released at T+INHIBIT_CYCLES+1.
- Data update: 3 `clk` cycles after the pin falling edge (sync latency), well inside the device low phase.
- `done`: exactly 1 cycle, in the cycle RECOVER sees both lines high. `tx_ready` = 1 in the following cycle.
- `ack_err` and `timeout` hold their value from the `done` pulse until the next accept.
- Simultaneous `clr` and `tx_valid`: `clr` wins and nothing is accepted.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined:
  - A cycle counter starts at accept.
  - If RECOVER is not reached within TIMEOUT_CYCLES cycles: both oe = 0, `timeout` = 1, `ack_err` = 1, `done` pulses, and the block returns to IDLE.
- Undefined: no watchdog logic and `timeout` is tied to 0. A silent device leaves the block in SEND until `clr`.

## Test plan
- Send 0xED (INHIBIT_CYCLES=50) with an ACKing device model -> clock held low 50 cycles; wire bits 0,1,0,1,1,0,1,1,1, parity 1, stop 1; `done` pulse; `ack_err` = 0.
- Send 0x01 and 0xFF back-to-back (`tx_valid` held high) -> parity 0 then 1; second accept in the cycle after `tx_ready` returns; two `done` pulses.
- Device never drives ACK (data stays high at edge 11) -> `done` with `ack_err` = 1; lines released.
- Device silent, TIMEOUT_CYCLES=2000, macro defined -> at accept+2000 both oe = 0, `timeout` = `ack_err` = 1, `done` pulse.
- `clr` asserted at edge 5 of a frame -> next cycle both oe = 0, `tx_ready` = 1, `busy` = 0, no `done`.
- Spurious device clock falls during INHIBIT plus `tx_valid` pulses while busy -> bit sequence unaffected; only the first byte is sent.
